idpipe: RTL

Instruction-decode pipeline stage: decodes a 32-bit instruction, reads two operands from a 32×32 register file, and registers ALU operands, op-select and carry-in for the execute stage. It sits directly upstream of the pipelined ALU stage and drives its abus, bbus, S and Cin inputs. The stage also carries destination and control bits forward and accepts the writeback port from the last stage.

---
 rtl/idpipe_pkg.sv | 62 ++++++
 rtl/idpipe_if.sv | 36 +++
 rtl/regfile32.sv | 53 +++++
 rtl/idpipe.sv | 109 ++++++++++
 4 files changed

// File: rtl/idpipe_pkg.sv
// idpipe_pkg: shared definitions for the instruction-decode stage.
//   - fixed datapath widths
//   - op-class codes and ALU select codes (the select codes match alu32)
//   - instruction field slice positions
//   - dec_t: the bundle of decoded values registered toward execute
//   - sext16: signed 16->32 immediate extension
package idpipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int SEL_W  = 3;
  localparam int NREGS  = 32;

  localparam logic [2:0] OP_R  = 3'b000;
  localparam logic [2:0] OP_I  = 3'b001;
  localparam logic [2:0] OP_LW = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;

  localparam logic [SEL_W-1:0] ALU_XOR  = 3'b000;
  localparam logic [SEL_W-1:0] ALU_XNOR = 3'b001;
  localparam logic [SEL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [SEL_W-1:0] ALU_SUB  = 3'b011;
  localparam logic [SEL_W-1:0] ALU_OR   = 3'b100;
  localparam logic [SEL_W-1:0] ALU_NOR  = 3'b101;
  localparam logic [SEL_W-1:0] ALU_AND  = 3'b110;
  localparam logic [SEL_W-1:0] ALU_NAND = 3'b111;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int FN_MSB  = 28;
  localparam int FN_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [DATA_W-1:0] abus;
    logic [DATA_W-1:0] bbus;
    logic [SEL_W-1:0]  s;
    logic              cin;
    logic [ADDR_W-1:0] dsel;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] sdata;
    logic              valid;
  } dec_t;

  localparam dec_t DEC_BUBBLE = '0;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    logic signed [15:0] imm_s;
    imm_s = imm;
    return 32'(imm_s);
  endfunction

endpackage

// File: rtl/idpipe_if.sv
// idpipe_if: bundles the decode stage's fetch, control, writeback and
// execute-side signals.
//   slave  : the decode stage (consumes ibus/stall/flush/wb_*, drives
//            abus/bbus/S/Cin/dsel/reg_we/mem_rd/mem_wr/sdata/valid)
//   master : the surrounding pipeline / environment
interface idpipe_if;
  import idpipe_pkg::*;

  logic [DATA_W-1:0] ibus;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [DATA_W-1:0] abus;
  logic [DATA_W-1:0] bbus;
  logic [SEL_W-1:0]  S;
  logic              Cin;
  logic [ADDR_W-1:0] dsel;
  logic              reg_we;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] sdata;
  logic              valid;

  modport slave (
    input  ibus, stall, flush, wb_en, wb_addr, wb_data,
    output abus, bbus, S, Cin, dsel, reg_we, mem_rd, mem_wr, sdata, valid
  );

  modport master (
    output ibus, stall, flush, wb_en, wb_addr, wb_data,
    input  abus, bbus, S, Cin, dsel, reg_we, mem_rd, mem_wr, sdata, valid
  );
endinterface

// File: rtl/regfile32.sv
// regfile32: 32 x 32 register file.
//   clk, rst_n   : clock, asynchronous active-low clear of all registers
//   ra_a, ra_b   : asynchronous read addresses; rd_a, rd_b read data
//   we, wa, wd   : synchronous write port
// R0 is not stored: it always reads 0 and writes to it are dropped.
// A read that matches a write in the same cycle returns the write data.
module regfile32
  import idpipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [1:NREGS-1];
  logic [DATA_W-1:0] mem_d [1:NREGS-1];

  always_comb begin
    mem_d = mem_q;
    if (we && (wa != '0)) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_a = '0;
    if (ra_a != '0) begin
      if (we && (wa == ra_a)) rd_a = wd;
      else                    rd_a = mem_q[ra_a];
    end
  end

  always_comb begin
    rd_b = '0;
    if (ra_b != '0) begin
      if (we && (wa == ra_b)) rd_b = wd;
      else                    rd_b = mem_q[ra_b];
    end
  end

endmodule

// File: rtl/idpipe.sv
// idpipe: instruction-decode stage feeding the pipelined ALU.
//   clk, rst_n : clock, asynchronous active-low reset (clears outputs
//                and the register file)
//   bus        : idpipe_if.slave -- ibus, stall, flush and the writeback
//                port in; ALU operands/select/carry, dsel, reg_we,
//                mem_rd, mem_wr, sdata and valid out (one cycle latency)
module idpipe
  import idpipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  idpipe_if.slave  bus
);

  logic [2:0]        op_p0;
  logic [2:0]        fn_p0;
  logic [ADDR_W-1:0] rs_p0;
  logic [ADDR_W-1:0] rt_p0;
  logic [ADDR_W-1:0] rd_p0;
  logic [15:0]       imm_p0;
  logic [DATA_W-1:0] ra_p0;
  logic [DATA_W-1:0] rb_p0;
  dec_t              dec_p0;
  dec_t              out_p1_d;
  dec_t              out_p1_q;

  assign op_p0  = bus.ibus[OP_MSB:OP_LSB];
  assign fn_p0  = bus.ibus[FN_MSB:FN_LSB];
  assign rs_p0  = bus.ibus[RS_MSB:RS_LSB];
  assign rt_p0  = bus.ibus[RT_MSB:RT_LSB];
  assign rd_p0  = bus.ibus[RD_MSB:RD_LSB];
  assign imm_p0 = bus.ibus[IMM_MSB:IMM_LSB];

  regfile32 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra_a  (rs_p0),
    .ra_b  (rt_p0),
    .rd_a  (ra_p0),
    .rd_b  (rb_p0),
    .we    (bus.wb_en),
    .wa    (bus.wb_addr),
    .wd    (bus.wb_data)
  );

  // Stage p0: combinational decode and operand read
  always_comb begin
    dec_p0       = DEC_BUBBLE;
    dec_p0.valid = 1'b1;
    unique case (op_p0)
      OP_R: begin
        dec_p0.abus   = ra_p0;
        dec_p0.bbus   = rb_p0;
        dec_p0.s      = fn_p0;
        dec_p0.dsel   = rd_p0;
        dec_p0.reg_we = 1'b1;
      end
      OP_I: begin
        dec_p0.abus   = ra_p0;
        dec_p0.bbus   = sext16(imm_p0);
        dec_p0.s      = fn_p0;
        dec_p0.dsel   = rt_p0;
        dec_p0.reg_we = 1'b1;
      end
      OP_LW: begin
        dec_p0.abus   = ra_p0;
        dec_p0.bbus   = sext16(imm_p0);
        dec_p0.s      = ALU_ADD;
        dec_p0.dsel   = rt_p0;
        dec_p0.reg_we = 1'b1;
        dec_p0.mem_rd = 1'b1;
      end
      OP_SW: begin
        dec_p0.abus   = ra_p0;
        dec_p0.bbus   = sext16(imm_p0);
        dec_p0.s      = ALU_ADD;
        dec_p0.sdata  = rb_p0;
        dec_p0.mem_wr = 1'b1;
      end
      default: ;
    endcase
    // The ALU subtracts as A + ~B + 1, so carry-in rides with SUB only.
    dec_p0.cin = (dec_p0.s == ALU_SUB);
  end

  // Stage p1: output registers (flush beats stall)
  always_comb begin
    out_p1_d = out_p1_q;
    if (bus.flush)       out_p1_d = DEC_BUBBLE;
    else if (!bus.stall) out_p1_d = dec_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_p1_q <= DEC_BUBBLE;
    else        out_p1_q <= out_p1_d;
  end

  assign bus.abus   = out_p1_q.abus;
  assign bus.bbus   = out_p1_q.bbus;
  assign bus.S      = out_p1_q.s;
  assign bus.Cin    = out_p1_q.cin;
  assign bus.dsel   = out_p1_q.dsel;
  assign bus.reg_we = out_p1_q.reg_we;
  assign bus.mem_rd = out_p1_q.mem_rd;
  assign bus.mem_wr = out_p1_q.mem_wr;
  assign bus.sdata  = out_p1_q.sdata;
  assign bus.valid  = out_p1_q.valid;

endmodule
